// File: rtl/code_lock_pkg.sv
// code_lock_pkg
// Shared definitions for the code_match_lock slice.
//   - state encoding for the lock FSM (IDLE, ENTRY, OPEN, LOCKOUT)
//   - clog2 helper and a counter-width helper used to size the
//     digit counter, failure counter, timers and key pointer
package code_lock_pkg;

  // Lock FSM state encoding, kept as plain constants so older blocks that
  // compare raw state bits keep working.
  localparam int         STATE_W    = 2;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENTRY   = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Bits needed for a counter that holds 0..n inclusive (never below 1).
  function automatic int cnt_width(input int n);
    return (clog2(n + 1) < 1) ? 1 : clog2(n + 1);
  endfunction

  // Bits needed to index n entries (never below 1).
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/code_key_store.sv
// code_key_store
// DEPTH x WIDTH register file holding the unlock key.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears all digits)
//   we        - write enable
//   wptr      - digit index to write
//   wdata     - digit value to write
//   rptr      - digit index to read (combinational)
//   rdata     - digit at rptr, zero when rptr is out of range
module code_key_store
  import code_lock_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int PW    = 2,
  parameter int RW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    wptr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RW-1:0]    rptr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Decoded write so pointer width never has to match the array range.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && (wptr == PW'(i))) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Read mux; the digit counter can reach DEPTH, which reads as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rptr == RW'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/code_match_lock.sv
// code_match_lock
// Compares a stream of entered digits against a stored DEPTH-digit key and
// opens only after the whole sequence matches. Counts consecutive failures,
// enforces a timed lockout, times out stalled entries and allows the key to
// be reprogrammed while open.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   code_valid  - a digit is presented on code_in this cycle
//   code_in     - entered digit
//   relock      - leave OPEN and return to IDLE
//   key_load    - write key_in into the key store (OPEN only)
//   key_in      - key digit to store
//   unlocked    - high while OPEN
//   locked_out  - high while in LOCKOUT
//   fail        - one-cycle pulse per failed attempt
//   digit_cnt   - digits accepted in the current attempt
//   fail_cnt    - consecutive failed attempts
module code_match_lock
  import code_lock_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int DEPTH          = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int ENTRY_TIMEOUT  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           code_valid,
  input  logic [WIDTH-1:0]               code_in,
  input  logic                           relock,
  input  logic                           key_load,
  input  logic [WIDTH-1:0]               key_in,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           fail,
  output logic [cnt_width(DEPTH)-1:0]    digit_cnt,
  output logic [cnt_width(MAX_FAIL)-1:0] fail_cnt
);

  localparam int DCW = cnt_width(DEPTH);
  localparam int FCW = cnt_width(MAX_FAIL);
  localparam int TMW = cnt_width((ENTRY_TIMEOUT > LOCKOUT_CYCLES) ?
                                 ENTRY_TIMEOUT : LOCKOUT_CYCLES);
  localparam int PW  = idx_width(DEPTH);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DCW-1:0]     dcnt_d;
  logic [FCW-1:0]     fcnt_d;
  logic [TMW-1:0]     tmr_q, tmr_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               mism_q, mism_d;
  logic               new_mism;
  logic               resolve;
  logic               fail_d;
  logic               key_we;
  logic [WIDTH-1:0]   key_rd;

  code_key_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW),
    .RW    (DCW)
  ) u_key_store (
    .clk   (clk),
    .rst   (rst),
    .we    (key_we),
    .wptr  (ptr_q),
    .wdata (key_in),
    .rptr  (digit_cnt),
    .rdata (key_rd)
  );

  // Next-state logic. The mismatch flag accumulates silently so the
  // position of a wrong digit is never revealed; the verdict is taken only
  // on the edge that samples digit DEPTH. One timer serves both the entry
  // timeout and the lockout since the two states never overlap.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = digit_cnt;
    fcnt_d   = fail_cnt;
    mism_d   = mism_q;
    tmr_d    = tmr_q;
    ptr_d    = ptr_q;
    fail_d   = 1'b0;
    key_we   = 1'b0;
    resolve  = 1'b0;
    new_mism = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (code_valid) begin
          new_mism = (code_in != key_rd);
          if (DEPTH == 1) begin
            resolve = 1'b1;
          end else begin
            state_d = ST_ENTRY;
            dcnt_d  = DCW'(1);
            mism_d  = new_mism;
          end
        end
      end

      ST_ENTRY: begin
        if (code_valid) begin
          new_mism = mism_q | (code_in != key_rd);
          tmr_d    = '0;
          if (digit_cnt == DCW'(DEPTH - 1)) begin
            resolve = 1'b1;
          end else begin
            dcnt_d = digit_cnt + DCW'(1);
            mism_d = new_mism;
          end
        end else if (tmr_q == TMW'(ENTRY_TIMEOUT - 1)) begin
          // Abandoned entry: silently discard, not counted as a failure.
          state_d = ST_IDLE;
          dcnt_d  = '0;
          mism_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMW'(1);
        end
      end

      ST_OPEN: begin
        if (key_load) begin
          key_we = 1'b1;
          ptr_d  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
        if (relock) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_q == TMW'(LOCKOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Verdict on the final digit of an attempt.
    if (resolve) begin
      dcnt_d = '0;
      mism_d = 1'b0;
      tmr_d  = '0;
      if (!new_mism) begin
        state_d = ST_OPEN;
        fcnt_d  = '0;
        ptr_d   = '0;
      end else begin
        fail_d = 1'b1;
        fcnt_d = fail_cnt + FCW'(1);
        if (fail_cnt == FCW'(MAX_FAIL - 1)) begin
          state_d = ST_LOCKOUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // State and output registers; status outputs are decoded from the next
  // state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      mism_q     <= 1'b0;
      tmr_q      <= '0;
      ptr_q      <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_cnt  <= dcnt_d;
      fail_cnt   <= fcnt_d;
      mism_q     <= mism_d;
      tmr_q      <= tmr_d;
      ptr_q      <= ptr_d;
      unlocked   <= (state_d == ST_OPEN);
      locked_out <= (state_d == ST_LOCKOUT);
      fail       <= fail_d;
    end
  end

endmodule

// File: tb/tb_code_match_lock.sv
// tb_code_match_lock
// Self-checking bench for code_match_lock: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model
// that keeps the entered digits in a queue and judges whole sequences.
module tb_code_match_lock;

  localparam int WIDTH          = 2;
  localparam int DEPTH          = 4;
  localparam int MAX_FAIL       = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int ENTRY_TIMEOUT  = 32;
  localparam int DCW            = 3;
  localparam int FCW            = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             code_valid = 1'b0;
  logic [WIDTH-1:0] code_in = '0;
  logic             relock = 1'b0;
  logic             key_load = 1'b0;
  logic [WIDTH-1:0] key_in = '0;
  logic             unlocked;
  logic             locked_out;
  logic             fail;
  logic [DCW-1:0]   digit_cnt;
  logic [FCW-1:0]   fail_cnt;

  int vectors     = 0;
  int miscompares = 0;

  code_match_lock #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .MAX_FAIL       (MAX_FAIL),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .ENTRY_TIMEOUT  (ENTRY_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_in    (code_in),
    .relock     (relock),
    .key_load   (key_load),
    .key_in     (key_in),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail       (fail),
    .digit_cnt  (digit_cnt),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the lock.
  typedef enum {M_CLOSED, M_TYPING, M_OPEN, M_LOCK} model_mode_e;

  model_mode_e mMode;
  int          mKey [DEPTH];
  int          mEntered [$];
  int          mFails;
  int          mLockLeft;
  int          mIdle;
  int          mPtr;
  bit          mFailPulse;

  task automatic modelReset();
    mMode = M_CLOSED;
    for (int i = 0; i < DEPTH; i++) mKey[i] = 0;
    mEntered.delete();
    mFails     = 0;
    mLockLeft  = 0;
    mIdle      = 0;
    mPtr       = 0;
    mFailPulse = 1'b0;
  endtask

  task automatic modelJudge();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mEntered[i] != mKey[i]) ok = 1'b0;
    end
    mEntered.delete();
    mIdle = 0;
    if (ok) begin
      mMode  = M_OPEN;
      mFails = 0;
      mPtr   = 0;
    end else begin
      mFailPulse = 1'b1;
      mFails     = mFails + 1;
      if (mFails == MAX_FAIL) begin
        mMode     = M_LOCK;
        mLockLeft = LOCKOUT_CYCLES;
      end else begin
        mMode = M_CLOSED;
      end
    end
  endtask

  task automatic modelStep(input bit cv, input int ci, input bit rl,
                           input bit kl, input int ki, input bit rs);
    mFailPulse = 1'b0;
    if (rs) begin
      modelReset();
    end else begin
      case (mMode)
        M_CLOSED, M_TYPING: begin
          if (cv) begin
            mEntered.push_back(ci);
            mIdle = 0;
            if (mEntered.size() == DEPTH) modelJudge();
            else mMode = M_TYPING;
          end else if (mMode == M_TYPING) begin
            mIdle = mIdle + 1;
            if (mIdle == ENTRY_TIMEOUT) begin
              mEntered.delete();
              mIdle = 0;
              mMode = M_CLOSED;
            end
          end
        end
        M_OPEN: begin
          if (kl) begin
            mKey[mPtr] = ki;
            mPtr = (mPtr + 1) % DEPTH;
          end
          if (rl) mMode = M_CLOSED;
        end
        M_LOCK: begin
          mLockLeft = mLockLeft - 1;
          if (mLockLeft == 0) begin
            mMode  = M_CLOSED;
            mFails = 0;
          end
        end
        default: mMode = M_CLOSED;
      endcase
    end
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors = vectors + 1;
    if (observed != expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s at %0t: observed %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, advance the model on
  // the rising edge, then compare every output just after it.
  task automatic applyStimulus(input bit cv, input int ci, input bit rl,
                               input bit kl, input int ki, input bit rs);
    @(negedge clk);
    code_valid = cv;
    code_in    = WIDTH'(ci);
    relock     = rl;
    key_load   = kl;
    key_in     = WIDTH'(ki);
    rst        = rs;
    @(posedge clk);
    modelStep(cv, ci % (1 << WIDTH), rl, kl, ki % (1 << WIDTH), rs);
    #1;
    checkOutput("unlocked",   int'(unlocked),   (mMode == M_OPEN) ? 1 : 0);
    checkOutput("locked_out", int'(locked_out), (mMode == M_LOCK) ? 1 : 0);
    checkOutput("fail",       int'(fail),       int'(mFailPulse));
    checkOutput("digit_cnt",  int'(digit_cnt),  mEntered.size());
    checkOutput("fail_cnt",   int'(fail_cnt),   mFails);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic enterCode(input int d0, input int d1, input int d2, input int d3);
    applyStimulus(1, d0, 0, 0, 0, 0);
    applyStimulus(1, d1, 0, 0, 0, 0);
    applyStimulus(1, d2, 0, 0, 0, 0);
    applyStimulus(1, d3, 0, 0, 0, 0);
  endtask

  initial begin
    modelReset();

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset_digit_cnt", int'(digit_cnt), 0);

    // Default all-zero key opens; then reprogram 3,1,2,0 with relock on the
    // last write.
    enterCode(0, 0, 0, 0);
    checkOutput("zero_key_unlocks", int'(unlocked), 1);
    applyStimulus(1, 2, 0, 1, 3, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 2, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("relock_closes", int'(unlocked), 0);
    enterCode(3, 1, 2, 0);
    checkOutput("new_key_unlocks", int'(unlocked), 1);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Single wrong attempt, last digit off
    enterCode(3, 1, 2, 1);
    checkOutput("wrong_fail_pulse", int'(fail), 1);
    checkOutput("wrong_fail_cnt", int'(fail_cnt), 1);
    idleCycles(1);
    checkOutput("fail_pulse_drops", int'(fail), 0);

    // Clear the counter, then three consecutive wrong attempts (back to back)
    enterCode(3, 1, 2, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    enterCode(0, 1, 2, 0);
    enterCode(3, 3, 2, 0);
    enterCode(2, 1, 2, 0);
    checkOutput("lockout_entered", int'(locked_out), 1);
    enterCode(3, 1, 2, 0);
    checkOutput("correct_ignored_in_lockout", int'(unlocked), 0);
    idleCycles(12);
    checkOutput("lockout_released", int'(locked_out), 0);
    checkOutput("lockout_clears_fail_cnt", int'(fail_cnt), 0);
    enterCode(3, 1, 2, 0);
    checkOutput("unlock_after_lockout", int'(unlocked), 1);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Entry timeout leaves the failure count alone
    enterCode(1, 1, 1, 1);
    applyStimulus(1, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    idleCycles(ENTRY_TIMEOUT - 1);
    checkOutput("timeout_not_yet", int'(digit_cnt), 2);
    idleCycles(1);
    checkOutput("timeout_digit_cnt", int'(digit_cnt), 0);
    checkOutput("timeout_keeps_fail_cnt", int'(fail_cnt), 1);
    enterCode(3, 1, 2, 0);
    checkOutput("unlock_after_timeout", int'(unlocked), 1);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Reset mid-entry restores the zero key; key_load while closed is ignored
    applyStimulus(1, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rst_mid_entry", int'(digit_cnt), 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 1, 3, 0);
    enterCode(0, 0, 0, 0);
    checkOutput("idle_key_load_ignored", int'(unlocked), 1);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Reset mid-lockout
    enterCode(1, 0, 0, 0);
    enterCode(0, 2, 0, 0);
    enterCode(0, 0, 0, 3);
    idleCycles(5);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rst_mid_lockout", int'(locked_out), 0);
    checkOutput("rst_mid_lockout_fail_cnt", int'(fail_cnt), 0);

    // Randomized run, biased toward correct digits so every state is visited
    for (int n = 0; n < 4000; n++) begin
      bit cv, rl, kl, rs;
      int ci, ki;
      rs = ($urandom_range(0, 299) == 0);
      cv = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) != 0 && mEntered.size() < DEPTH)
        ci = mKey[mEntered.size()];
      else
        ci = $urandom_range(0, (1 << WIDTH) - 1);
      kl = ($urandom_range(0, 3) == 0);
      ki = $urandom_range(0, (1 << WIDTH) - 1);
      rl = ($urandom_range(0, 7) == 0);
      applyStimulus(cv, ci, rl, kl, ki, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/code_match_lock.md
# code_match_lock

Sequential, parametrised successor to the team's combinational 2-bit equality comparator. It compares a stream of WIDTH-bit entered codes against a stored DEPTH-digit key and asserts `unlocked` only after the full sequence matches. It adds failure counting, a timed lockout, an entry timeout, and key reprogramming while open. It sits between switch/button entry logic and the LED/actuator drive.

## Interface
- WIDTH, 2: bits per code digit (≥1)
- DEPTH, 4: digits per key sequence (≥1)
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (≥1)
- LOCKOUT_CYCLES, 16: clock cycles spent in lockout (≥1)
- ENTRY_TIMEOUT, 32: idle cycles allowed between digits during entry (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- code_valid  in  1  one digit presented on code_in this cycle
- code_in  in  WIDTH  entered digit
- relock  in  1  return from OPEN to IDLE
- key_load  in  1  write key_in into key store (honoured only in OPEN)
- key_in  in  WIDTH  key digit to store
- unlocked  out  1  high while in OPEN
- locked_out  out  1  high while in LOCKOUT
- fail  out  1  one-cycle pulse per failed attempt
- digit_cnt  out  clog2(DEPTH+1)  digits accepted in current attempt
- fail_cnt  out  clog2(MAX_FAIL+1)  consecutive failures

## Operation
- States: IDLE, ENTRY, OPEN, LOCKOUT. All outputs registered.
- Reset values: state IDLE; unlocked=0, locked_out=0, fail=0, digit_cnt=0, fail_cnt=0, all key digits=0, load_ptr=0, timers=0.
- IDLE, code_valid:
  - Compare code_in with key[0] and set mismatch flag = (code_in != key[0]).
  - digit_cnt=1. Go to ENTRY. If DEPTH==1, resolve immediately instead (see resolution).
- ENTRY, code_valid:
  - Compare code_in with key[digit_cnt] and OR the result into mismatch.
  - digit_cnt increments and the timeout timer clears.
  - No early rejection; the mismatch position is never revealed.
- Resolution, on the edge sampling digit DEPTH:
  - No mismatch: go to OPEN, fail_cnt=0, digit_cnt=0, load_ptr=0.
  - Mismatch: fail=1 for one cycle, fail_cnt+1, digit_cnt=0. If the new fail_cnt==MAX_FAIL, go to LOCKOUT; else go to IDLE.
- ENTRY timeout: ENTRY_TIMEOUT consecutive cycles without code_valid returns to IDLE and sets digit_cnt=0. This is not a failure: no fail pulse, fail_cnt unchanged.
- OPEN:
  - code_valid is ignored.
  - key_load writes key[load_ptr] <= key_in. load_ptr increments and wraps DEPTH-1 -> 0.
  - relock goes to IDLE.
- LOCKOUT:
  - code_valid, key_load and relock are ignored.
  - Stays exactly LOCKOUT_CYCLES cycles, then goes to IDLE with fail_cnt=0.
- key_load outside OPEN has no effect, and the key store is unchanged.

## Timing
- Inputs are sampled on the rising clk edge.
- Decision latency: unlocked or fail is visible in the cycle after the edge that samples digit DEPTH.
- Back-to-back code_valid every cycle is supported; there is no throughput limit.
- locked_out rises in the cycle after the failing edge. It is high for LOCKOUT_CYCLES cycles, and IDLE is reached on the following edge.
- Simultaneous key_load and relock in OPEN: the write is performed and state goes to IDLE. The new key applies to the next attempt.
- code_valid in the same cycle as the resolution edge belongs to that attempt only. The next attempt starts with the next code_valid.
- rst dominates all inputs in any state, including mid-entry and mid-lockout. The stored key returns to all zeros.

## Structure
- Shared package `code_lock_pkg`:
  - state enum (IDLE, ENTRY, OPEN, LOCKOUT)
  - clog2 helper
  - width localparams for digit_cnt, fail_cnt and timers
- Sub-module `code_key_store`: a DEPTH×WIDTH register file.
  - Write port: we, wptr, wdata.
  - Combinational read port indexed by digit_cnt.
  - Synchronous reset to zeros.
- FSM, counters and comparator live in the top.

## Test plan
- After rst, enter 0,0,0,0 (WIDTH=2, DEPTH=4) -> unlocked=1 the cycle after the 4th digit; fail_cnt=0.
- In OPEN, key_load 3,1,2,0 then relock; enter 3,1,2,0 -> unlocked. Enter 3,1,2,1 -> a single fail pulse, fail_cnt=1, unlocked stays 0, state IDLE.
- Three consecutive wrong sequences -> locked_out=1 for 16 cycles. A correct sequence entered during lockout is ignored. Then IDLE with fail_cnt=0, and the correct sequence unlocks.
- Enter 2 digits, then 32 idle cycles -> digit_cnt=0, no fail, fail_cnt unchanged. A full correct sequence then unlocks.
- key_load in IDLE with key_in=3 -> key unchanged; all-zero sequence still unlocks.
- rst asserted mid-entry and again mid-lockout -> all outputs return to reset values next cycle; key back to zeros.
